// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage register uses the slave view; the upstream/downstream driver uses the master view.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int TNEW_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [TNEW_W-1:0] in_tnew;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [TNEW_W-1:0] out_tnew;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_pc, in_tnew, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_tnew, out_data
  );

  modport master (
    output in_valid, in_pc, in_tnew, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_tnew, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a one-entry skid buffer, flush-to-bubble
// and saturating Tnew decrement. Stalls appear upstream only as in_ready=0.
module pipe_stage_skid #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RST   = PC_W'(32'h3000),
  parameter int              TNEW_W   = 2,
  parameter bit              TNEW_DEC = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          occ
);

  function automatic logic [TNEW_W-1:0] tnew_capture(input logic [TNEW_W-1:0] t);
    if (!TNEW_DEC) begin
      return t;
    end else if (t == {TNEW_W{1'b0}}) begin
      return {TNEW_W{1'b0}};
    end else begin
      return t - TNEW_W'(1);
    end
  endfunction

  logic              main_v_r, skid_v_r;
  logic [PC_W-1:0]   main_pc_r, skid_pc_r;
  logic [TNEW_W-1:0] main_tnew_r, skid_tnew_r;
  logic [DATA_W-1:0] main_data_r, skid_data_r;
  logic [1:0]        occ_r;

  logic              main_v_s, skid_v_s;
  logic [PC_W-1:0]   main_pc_s, skid_pc_s;
  logic [TNEW_W-1:0] main_tnew_s, skid_tnew_s;
  logic [DATA_W-1:0] main_data_s, skid_data_s;
  logic [1:0]        occ_s;
  logic              acc_s, pop_s;
  logic [TNEW_W-1:0] in_tnew_s;

  // Next-state selection for the main and skid entries
  always_comb begin
    acc_s       = bus.in_valid & ~skid_v_r;
    pop_s       = main_v_r & bus.out_ready;
    in_tnew_s   = tnew_capture(bus.in_tnew);
    main_v_s    = main_v_r;
    main_pc_s   = main_pc_r;
    main_tnew_s = main_tnew_r;
    main_data_s = main_data_r;
    skid_v_s    = skid_v_r;
    skid_pc_s   = skid_pc_r;
    skid_tnew_s = skid_tnew_r;
    skid_data_s = skid_data_r;
    if (flush) begin
      // out_pc keeps its last value; payload is cleared so the bubble is a nop
      main_v_s    = 1'b0;
      main_tnew_s = {TNEW_W{1'b0}};
      main_data_s = {DATA_W{1'b0}};
      skid_v_s    = 1'b0;
      skid_tnew_s = {TNEW_W{1'b0}};
      skid_data_s = {DATA_W{1'b0}};
    end else if (!main_v_r) begin
      if (acc_s) begin
        main_v_s    = 1'b1;
        main_pc_s   = bus.in_pc;
        main_tnew_s = in_tnew_s;
        main_data_s = bus.in_data;
      end else begin
        main_v_s    = 1'b0;
      end
    end else if (pop_s) begin
      if (skid_v_r) begin
        // skid is always older than anything upstream, so it goes first
        main_pc_s   = skid_pc_r;
        main_tnew_s = skid_tnew_r;
        main_data_s = skid_data_r;
        skid_v_s    = 1'b0;
      end else if (acc_s) begin
        main_pc_s   = bus.in_pc;
        main_tnew_s = in_tnew_s;
        main_data_s = bus.in_data;
      end else begin
        main_v_s    = 1'b0;
        main_tnew_s = {TNEW_W{1'b0}};
        main_data_s = {DATA_W{1'b0}};
      end
    end else begin
      if (acc_s) begin
        skid_v_s    = 1'b1;
        skid_pc_s   = bus.in_pc;
        skid_tnew_s = in_tnew_s;
        skid_data_s = bus.in_data;
      end else begin
        skid_v_s    = skid_v_r;
      end
    end
    occ_s = {1'b0, main_v_s} + {1'b0, skid_v_s};
  end

  // State registers; reset overrides flush and incoming data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_r    <= 1'b0;
      main_pc_r   <= PC_RST;
      main_tnew_r <= {TNEW_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_v_r    <= 1'b0;
      skid_pc_r   <= PC_RST;
      skid_tnew_r <= {TNEW_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      occ_r       <= 2'd0;
    end else begin
      main_v_r    <= main_v_s;
      main_pc_r   <= main_pc_s;
      main_tnew_r <= main_tnew_s;
      main_data_r <= main_data_s;
      skid_v_r    <= skid_v_s;
      skid_pc_r   <= skid_pc_s;
      skid_tnew_r <= skid_tnew_s;
      skid_data_r <= skid_data_s;
      occ_r       <= occ_s;
    end
  end

  assign bus.in_ready  = ~skid_v_r;
  assign bus.out_valid = main_v_r;
  assign bus.out_pc    = main_pc_r;
  assign bus.out_tnew  = main_tnew_r;
  assign bus.out_data  = main_data_r;
  assign occ           = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector bench for pipe_stage_skid: two instances (Tnew decrement on/off)
// receive identical stimulus; expected values are hand-computed constants.
module tb_pipe_stage_skid;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occ1, occ0;
  int         n_chk;
  int         n_fail;

  pipe_stage_skid_if #(.DATA_W(32), .PC_W(32), .TNEW_W(2)) b1 ();
  pipe_stage_skid_if #(.DATA_W(32), .PC_W(32), .TNEW_W(2)) b0 ();

  pipe_stage_skid #(.TNEW_DEC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1), .occ(occ1));
  pipe_stage_skid #(.TNEW_DEC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0), .occ(occ0));

  assign b0.in_valid  = b1.in_valid;
  assign b0.in_pc     = b1.in_pc;
  assign b0.in_tnew   = b1.in_tnew;
  assign b0.in_data   = b1.in_data;
  assign b0.out_ready = b1.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] tn);
    b1.in_valid = v;
    b1.in_pc    = pc;
    b1.in_tnew  = tn;
    b1.in_data  = dat(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    b1.out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    b1.out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0);
    tick();
    n_chk++;
    if ({b1.out_valid, b1.out_pc, occ1, b1.in_ready, b1.out_data, b1.out_tnew} !==
        {1'b0, 32'h3000, 2'd0, 1'b1, 32'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b pc=%h occ=%0d rdy=%b data=%h tnew=%0d required v=0 pc=3000 occ=0 rdy=1 data=0 tnew=0",
               b1.out_valid, b1.out_pc, occ1, b1.in_ready, b1.out_data, b1.out_tnew);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs = '{32'h3000, 32'h3004, 32'h3008};
    do_reset();
    b1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], 2'd0);
      tick();
      n_chk++;
      if ({b1.out_valid, b1.out_pc, b1.out_data, occ1, b1.in_ready} !==
          {1'b1, pcs[i], dat(pcs[i]), 2'd1, 1'b1}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h data=%h occ=%0d rdy=%b required v=1 pc=%h data=%h occ=1 rdy=1",
                 i, b1.out_valid, b1.out_pc, b1.out_data, occ1, b1.in_ready, pcs[i], dat(pcs[i]));
      end
    end
    drive(1'b0, 32'h0, 2'd0);
    tick();
    n_chk++;
    if ({b1.out_valid, occ1, b1.out_data} !== {1'b0, 2'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b occ=%0d data=%h required v=0 occ=0 data=0",
               b1.out_valid, occ1, b1.out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [5];
    logic [1:0]  exp_occ [5];
    logic        exp_rdy [5];
    exp_pc  = '{32'h3000, 32'h3000, 32'h3000, 32'h3004, 32'h3008};
    exp_occ = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      // 3008 stays on the input until an edge where in_ready was high
      case (i)
        0:       drive(1'b1, 32'h3000, 2'd0);
        1:       drive(1'b1, 32'h3004, 2'd0);
        default: drive(1'b1, 32'h3008, 2'd0);
      endcase
      b1.out_ready = (i >= 3) ? 1'b1 : 1'b0;
      tick();
      n_chk++;
      if ({b1.out_valid, b1.out_pc, b1.out_data, occ1, b1.in_ready} !==
          {1'b1, exp_pc[i], dat(exp_pc[i]), exp_occ[i], exp_rdy[i]}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got v=%b pc=%h data=%h occ=%0d rdy=%b required v=1 pc=%h data=%h occ=%0d rdy=%b",
                 i, b1.out_valid, b1.out_pc, b1.out_data, occ1, b1.in_ready,
                 exp_pc[i], dat(exp_pc[i]), exp_occ[i], exp_rdy[i]);
      end
    end
    drive(1'b0, 32'h0, 2'd0);
    tick();
    n_chk++;
    if ({b1.out_valid, occ1} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL backpressure_drain: got v=%b occ=%0d required v=0 occ=0", b1.out_valid, occ1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h3040, 2'd2);
    tick();
    drive(1'b1, 32'h3044, 2'd2);
    tick();
    n_chk++;
    if (occ1 !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_fill: got occ=%0d required occ=2", occ1);
    end
    drive(1'b1, 32'h300c, 2'd2);
    flush = 1'b1;
    b1.out_ready = 1'b1;
    tick();
    n_chk++;
    if ({b1.out_valid, occ1, b1.out_data, b1.out_tnew, b1.in_ready, b1.out_pc} !==
        {1'b0, 2'd0, 32'h0, 2'd0, 1'b1, 32'h3040}) begin
      n_fail++;
      $display("FAIL flush: got v=%b occ=%0d data=%h tnew=%0d rdy=%b pc=%h required v=0 occ=0 data=0 tnew=0 rdy=1 pc=3040",
               b1.out_valid, occ1, b1.out_data, b1.out_tnew, b1.in_ready, b1.out_pc);
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if ({b1.out_valid, occ1} !== {1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: got v=%b occ=%0d pc=%h required v=0 occ=0",
                 i, b1.out_valid, occ1, b1.out_pc);
      end
    end
  endtask

  task automatic test_tnew();
    logic [1:0] tin  [4];
    logic [1:0] exp1 [4];
    logic [1:0] exp0 [4];
    tin  = '{2'd2, 2'd1, 2'd0, 2'd3};
    exp1 = '{2'd1, 2'd0, 2'd0, 2'd2};
    exp0 = '{2'd2, 2'd1, 2'd0, 2'd3};
    do_reset();
    b1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3100 + 32'(i * 4), tin[i]);
      tick();
      n_chk++;
      if (b1.out_tnew !== exp1[i]) begin
        n_fail++;
        $display("FAIL tnew_dec[%0d]: got %0d required %0d", i, b1.out_tnew, exp1[i]);
      end
      n_chk++;
      if (b0.out_tnew !== exp0[i]) begin
        n_fail++;
        $display("FAIL tnew_nodec[%0d]: got %0d required %0d", i, b0.out_tnew, exp0[i]);
      end
    end
    drive(1'b0, 32'h0, 2'd0);
    tick();
    n_chk++;
    if ({b1.out_tnew, b0.out_tnew} !== {2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL tnew_bubble: got %0d/%0d required 0/0", b1.out_tnew, b0.out_tnew);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 32'h3020, 2'd1);
    tick();
    drive(1'b1, 32'h3024, 2'd1);
    tick();
    n_chk++;
    if (occ1 !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got occ=%0d required occ=2", occ1);
    end
    rst_n = 1'b0;
    drive(1'b1, 32'h3028, 2'd1);
    tick();
    n_chk++;
    if ({b1.out_valid, b1.out_pc, occ1, b1.in_ready, b1.out_data} !==
        {1'b0, 32'h3000, 2'd0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b pc=%h occ=%0d rdy=%b data=%h required v=0 pc=3000 occ=0 rdy=1 data=0",
               b1.out_valid, b1.out_pc, occ1, b1.in_ready, b1.out_data);
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 2'd0);
    tick();
    n_chk++;
    if ({b1.out_valid, occ1} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_after: got v=%b occ=%0d pc=%h required v=0 occ=0",
               b1.out_valid, occ1, b1.out_pc);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    b1.out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_tnew();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
